// File: rtl/health_link_controller.sv
// Session FSM for a serial health-data link plus an independent round-robin
// abnormality warning scheduler.
module health_link_controller #(
  parameter int FRAME_BITS = 8,
  parameter int TIMEOUT    = 16,
  parameter int WARN_HOLD  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  request,
  input  logic                  confirm,
  input  logic                  inputdata,
  input  logic [5:0]            abnormalityVector,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frameValid,
  output logic                  busy,
  output logic                  timeoutErr,
  output logic [2:0]            state,
  output logic [2:0]            abnormalityWarning,
  output logic [2:0]            abnormalityCount
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int HW = (WARN_HOLD > 1) ? $clog2(WARN_HOLD) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT_CONFIRM = 3'd1, RECEIVE = 3'd2, DELIVER = 3'd3, ERROR = 3'd4
  } state_t;

  state_t                curState;
  logic [TW-1:0]         tCnt;
  logic [BW-1:0]         bitCnt;
  logic [FRAME_BITS-1:0] shiftReg;
  logic [2:0]            lastIdx;
  logic [HW-1:0]         holdCnt;
  logic [2:0]            nextIdx;
  logic [3:0]            cand;

  assign state = curState;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      curState   <= IDLE;
      tCnt       <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      frame      <= '0;
      frameValid <= 1'b0;
      busy       <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      frameValid <= 1'b0;
      case (curState)
        IDLE: if (request) begin
          curState <= WAIT_CONFIRM;
          busy     <= 1'b1;
          tCnt     <= '0;
        end
        WAIT_CONFIRM: begin
          if (!request) begin
            curState <= IDLE;
            busy     <= 1'b0;
          end else if (confirm) begin
            curState <= RECEIVE;
            bitCnt   <= '0;
            shiftReg <= '0;
          end else if (tCnt == TW'(TIMEOUT - 1)) begin
            curState   <= ERROR;
            timeoutErr <= 1'b1;
          end else begin
            tCnt <= tCnt + 1'b1;
          end
        end
        RECEIVE: begin
          if (!request) begin
            curState <= IDLE;
            busy     <= 1'b0;
          end else begin
            shiftReg <= {shiftReg[FRAME_BITS-2:0], inputdata};
            bitCnt   <= bitCnt + 1'b1;
            if (bitCnt == BW'(FRAME_BITS - 1)) begin
              frame      <= {shiftReg[FRAME_BITS-2:0], inputdata};
              frameValid <= 1'b1;
              curState   <= DELIVER;
            end
          end
        end
        DELIVER: begin
          // Next frame starts straight away; the earlier confirm still holds.
          if (request) begin
            curState <= RECEIVE;
            bitCnt   <= '0;
            shiftReg <= '0;
          end else begin
            curState <= IDLE;
            busy     <= 1'b0;
          end
        end
        ERROR: if (!request) begin
          curState   <= IDLE;
          busy       <= 1'b0;
          timeoutErr <= 1'b0;
        end
        default: begin
          curState   <= IDLE;
          busy       <= 1'b0;
          timeoutErr <= 1'b0;
        end
      endcase
    end
  end

  // First set bit strictly after lastIdx, wrapping; descending loop so the nearest wins.
  always_comb begin
    nextIdx = lastIdx;
    cand    = '0;
    for (int k = 6; k >= 1; k--) begin
      cand = {1'b0, lastIdx} + 4'(k);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (abnormalityVector[cand[2:0]]) nextIdx = cand[2:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lastIdx            <= 3'd5;
      holdCnt            <= '0;
      abnormalityWarning <= 3'd0;
      abnormalityCount   <= 3'd0;
    end else begin
      abnormalityCount <= 3'($countones(abnormalityVector));
      if (abnormalityVector == 6'd0) begin
        abnormalityWarning <= 3'd0;
        holdCnt            <= '0;
      end else if (abnormalityWarning == 3'd0 || holdCnt == HW'(WARN_HOLD - 1)) begin
        abnormalityWarning <= nextIdx + 3'd1;
        lastIdx            <= nextIdx;
        holdCnt            <= '0;
      end else begin
        holdCnt <= holdCnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_health_link_controller.sv
// Scoreboarded bench for health_link_controller: frames queued on drive,
// popped on frameValid; FSM and warning scheduler checked directly.
module tb_health_link_controller;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       request = 1'b0, confirm = 1'b0, inputdata = 1'b0;
  logic [5:0] abnormalityVector = 6'd0;
  logic [7:0] frame;
  logic       frameValid, busy, timeoutErr;
  logic [2:0] state, abnormalityWarning, abnormalityCount;

  int tests = 0, fails = 0, cyc = 0;
  int fvCyc[$];
  logic [7:0] sb[$];

  health_link_controller #(.FRAME_BITS(8), .TIMEOUT(16), .WARN_HOLD(4)) dut (
    .clock(clock), .reset(reset), .request(request), .confirm(confirm),
    .inputdata(inputdata), .abnormalityVector(abnormalityVector), .frame(frame),
    .frameValid(frameValid), .busy(busy), .timeoutErr(timeoutErr), .state(state),
    .abnormalityWarning(abnormalityWarning), .abnormalityCount(abnormalityCount)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] w);
    sb.push_back(w);
    for (int i = 7; i >= 0; i--) begin
      inputdata = w[i];
      tick();
    end
  endtask

  task automatic handshake();
    request = 1'b1; tick();
    confirm = 1'b1; tick();
    confirm = 1'b0;
  endtask

  // Scoreboard side: every frameValid pulse consumes one expected frame.
  always @(negedge clock) begin
    if (!reset && frameValid) begin
      fvCyc.push_back(cyc);
      if (sb.size() == 0) check("unexpectedFrameValid", 1, 0);
      else check("frame", frame, sb.pop_front());
    end
  end

  initial begin
    logic [2:0] codes [3];
    codes[0] = 3'd2; codes[1] = 3'd3; codes[2] = 3'd5;

    #2;
    check("rstState", state, 0);
    check("rstFrame", frame, 0);
    check("rstBusy", {busy, timeoutErr, frameValid}, 0);
    check("rstWarn", {abnormalityWarning, abnormalityCount}, 0);
    @(negedge clock); reset = 1'b0;
    tick();

    // Single frame 8'hAA, request dropped in DELIVER.
    request = 1'b1; tick();
    check("waitState", state, 1);
    check("waitBusy", busy, 1);
    confirm = 1'b1; tick(); confirm = 1'b0;
    check("rxState", state, 2);
    sendFrame(8'hAA);
    check("deliverState", state, 3);
    check("fvPulse", frameValid, 1);
    request = 1'b0; tick();
    check("backIdle", state, 0);
    check("fvDropped", frameValid, 0);
    check("idleBusy", busy, 0);

    // Back-to-back frames under one handshake.
    handshake();
    sendFrame(8'h0F);
    inputdata = 1'b1; tick();
    check("deliverToRx", state, 2);
    sendFrame(8'hE0);
    request = 1'b0; tick();
    check("b2bIdle", state, 0);
    check("fvCount", fvCyc.size(), 3);
    if (fvCyc.size() == 3) check("fvGap", fvCyc[2] - fvCyc[1], 9);
    check("frameHold", frame, 8'hE0);

    // Confirm never arrives.
    request = 1'b1; tick();
    for (int i = 0; i < 15; i++) tick();
    check("preTimeout", state, 1);
    tick();
    check("timeoutState", state, 4);
    check("timeoutErr", timeoutErr, 1);
    confirm = 1'b1; tick(); confirm = 1'b0;
    check("errSticky", state, 4);
    request = 1'b0; tick();
    check("errToIdle", state, 0);
    check("errCleared", timeoutErr, 0);

    // Abort after 5 bits: frame retained, no pulse.
    handshake();
    for (int i = 0; i < 5; i++) begin inputdata = i[0]; tick(); end
    request = 1'b0; tick();
    check("abortIdle", state, 0);
    check("abortFrame", frame, 8'hE0);
    tick();
    check("abortNoFv", fvCyc.size(), 3);

    // Asynchronous reset between edges mid-RECEIVE.
    handshake();
    for (int i = 0; i < 3; i++) begin inputdata = 1'b1; tick(); end
    #2 reset = 1'b1;
    #1;
    check("asyncState", state, 0);
    check("asyncFrame", frame, 0);
    check("asyncBusy", busy, 0);
    @(negedge clock); reset = 1'b0;
    request = 1'b1; confirm = 1'b1; tick();
    check("rehandshake", state, 1);
    tick();
    check("rehandshakeRx", state, 2);
    request = 1'b0; confirm = 1'b0; tick();
    check("rstIdle", state, 0);

    // Warning scheduler round-robin.
    abnormalityVector = 6'b010110;
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("warnSeq%0d", i), abnormalityWarning, codes[(i / 4) % 3]);
    end
    check("abnCount", abnormalityCount, 3);
    abnormalityVector = 6'd0; tick();
    check("warnClear", abnormalityWarning, 0);
    check("countClear", abnormalityCount, 0);
    abnormalityVector = 6'b010110; tick();
    check("warnResume", abnormalityWarning, 3);
    abnormalityVector = 6'd0; tick();
    abnormalityVector = 6'b001000;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("warnSingle%0d", i), abnormalityWarning, 4);
    end
    check("singleCount", abnormalityCount, 1);

    check("sbEmpty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
